csel_subtractor_pipe: RTL and testbench

//  Pipelined carry-select subtractor: diff = a - b - bin (mod 2^WIDTH), with borrow-out,

---
 rtl/csel_subtractor_pipe_pkg.sv | 19 +
 rtl/csel_subtractor_pipe_fsub.sv | 17 +
 rtl/csel_subtractor_pipe.sv | 189 ++++++++++++++++++
 tb/tb_csel_subtractor_pipe.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/csel_subtractor_pipe_pkg.sv
// Shared parameters for the carry-select add/subtract datapath.
// Holds default widths, the block-count derivation and a legality check
// so the adder and subtractor agree on how operands are split.
package csel_subtractor_pipe_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;
    localparam int unsigned DEFAULT_BLOCK = 4;

    // Number of carry-select blocks; guarded so an illegal BLOCK=0 cannot divide by zero.
    function automatic int unsigned calc_nblk(input int unsigned width, input int unsigned block);
        return (block == 0) ? 0 : width / block;
    endfunction

    // A configuration is legal when blocks tile the operand exactly.
    function automatic bit params_ok(input int unsigned width, input int unsigned block);
        return (block >= 1) && (width >= block) && ((width % block) == 0);
    endfunction

endpackage

// File: rtl/csel_subtractor_pipe_fsub.sv
// Gate-level one-bit full subtractor, the subtract twin of the adder cell.
// d = x - y - bi (one bit), bo = borrow out.
module full_subtractor (
    output logic d,
    output logic bo,
    input  logic x,
    input  logic y,
    input  logic bi
);

    logic x_xor_y;

    assign x_xor_y = x ^ y;
    assign d       = x_xor_y ^ bi;
    assign bo      = (~x & y) | (~x_xor_y & bi);

endmodule

// File: rtl/csel_subtractor_pipe.sv
// Two-stage pipelined carry-select subtractor: diff = a - b - bin.
// Stage 1 registers both borrow-in candidates of every upper block (block 0
// uses the real bin); stage 2 ripples the block borrows through the select
// chain and registers diff plus the bout/ovf/zero flags.
module csel_subtractor_pipe
    import csel_subtractor_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned BLOCK = DEFAULT_BLOCK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned NBLK = calc_nblk(WIDTH, BLOCK);
    // Upper-block arrays keep one unused, tied-off entry when there is a single block.
    localparam int unsigned NHI  = (NBLK > 1) ? NBLK - 1 : 1;

    if (!params_ok(WIDTH, BLOCK)) begin : g_param_check
        $error("csel_subtractor_pipe: WIDTH must be a non-zero multiple of BLOCK");
    end

    // Handshake control
    logic s1_valid_q, s1_valid_d;
    logic out_valid_q, out_valid_d;
    logic s2_adv, in_fire, s1_to_s2;

    // Stage-1 candidates (_d = combinational from operands, _q = registered)
    logic [BLOCK-1:0]          blk0_d_d, blk0_d_q;
    logic                      blk0_bo_d, blk0_bo_q;
    logic [NHI-1:0][BLOCK-1:0] hi_d0_d, hi_d0_q, hi_d1_d, hi_d1_q;
    logic [NHI-1:0]            hi_bo0_d, hi_bo0_q, hi_bo1_d, hi_bo1_q;
    logic                      a_msb_q, b_msb_q;

    // Stage-2 result
    logic [WIDTH-1:0] diff_d, diff_q;
    logic             bout_d, bout_q, ovf_d, ovf_q, zero_d, zero_q;
    logic             chain_borrow;

    assign s2_adv   = !out_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_adv;
    assign in_fire  = in_valid && in_ready;
    assign s1_to_s2 = s2_adv && s1_valid_q;

    // Candidate generators: block 0 from the real bin, upper blocks for both borrow-ins.
    for (genvar k = 0; k < NBLK; k++) begin : g_blk
        if (k == 0) begin : g_lo
            logic [BLOCK:0] br;
            assign br[0] = bin;
            for (genvar i = 0; i < BLOCK; i++) begin : g_bit
                full_subtractor u_fs (
                    .d (blk0_d_d[i]),
                    .bo(br[i+1]),
                    .x (a[i]),
                    .y (b[i]),
                    .bi(br[i])
                );
            end
            assign blk0_bo_d = br[BLOCK];
        end else begin : g_hi
            logic [BLOCK:0]   br0, br1;
            logic [BLOCK-1:0] d0, d1;
            assign br0[0] = 1'b0;
            assign br1[0] = 1'b1;
            for (genvar i = 0; i < BLOCK; i++) begin : g_bit
                full_subtractor u_fs0 (
                    .d (d0[i]),
                    .bo(br0[i+1]),
                    .x (a[k*BLOCK+i]),
                    .y (b[k*BLOCK+i]),
                    .bi(br0[i])
                );
                full_subtractor u_fs1 (
                    .d (d1[i]),
                    .bo(br1[i+1]),
                    .x (a[k*BLOCK+i]),
                    .y (b[k*BLOCK+i]),
                    .bi(br1[i])
                );
            end
            assign hi_d0_d[k-1]  = d0;
            assign hi_d1_d[k-1]  = d1;
            assign hi_bo0_d[k-1] = br0[BLOCK];
            assign hi_bo1_d[k-1] = br1[BLOCK];
        end
    end

    if (NBLK == 1) begin : g_no_hi
        assign hi_d0_d  = '0;
        assign hi_d1_d  = '0;
        assign hi_bo0_d = '0;
        assign hi_bo1_d = '0;
    end

    // Next-state of the two valid bits from the handshake.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (which would infer a latch).
        s1_valid_d  = s1_valid_q;
        out_valid_d = out_valid_q;
        if (in_fire) begin
            s1_valid_d = 1'b1;
        end else if (s2_adv) begin
            s1_valid_d = 1'b0;
        end
        if (s2_adv) begin
            out_valid_d = s1_valid_q;
        end
    end

    // Select chain: each block's registered borrow picks the next block's candidate.
    always_comb begin
        diff_d              = '0;
        diff_d[BLOCK-1:0]   = blk0_d_q;
        chain_borrow        = blk0_bo_q;
        for (int k = 1; k < NBLK; k++) begin
            diff_d[k*BLOCK +: BLOCK] = chain_borrow ? hi_d1_q[k-1] : hi_d0_q[k-1];
            chain_borrow             = chain_borrow ? hi_bo1_q[k-1] : hi_bo0_q[k-1];
        end
        bout_d = chain_borrow;
        ovf_d  = (a_msb_q != b_msb_q) && (diff_d[WIDTH-1] != a_msb_q);
        zero_d = (diff_d == '0);
    end

    // Stage 1: capture candidates and operand sign bits on input transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: datapath registers are reset too, so outputs are defined (never X) straight out of reset.
            s1_valid_q <= 1'b0;
            blk0_d_q   <= '0;
            blk0_bo_q  <= 1'b0;
            hi_d0_q    <= '0;
            hi_d1_q    <= '0;
            hi_bo0_q   <= '0;
            hi_bo1_q   <= '0;
            a_msb_q    <= 1'b0;
            b_msb_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples pre-edge values, independent of block order.
            s1_valid_q <= s1_valid_d;
            if (in_fire) begin
                blk0_d_q  <= blk0_d_d;
                blk0_bo_q <= blk0_bo_d;
                hi_d0_q   <= hi_d0_d;
                hi_d1_q   <= hi_d1_d;
                hi_bo0_q  <= hi_bo0_d;
                hi_bo1_q  <= hi_bo1_d;
                a_msb_q   <= a[WIDTH-1];
                b_msb_q   <= b[WIDTH-1];
            end
        end
    end

    // Stage 2: register the selected result when the output slot advances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            diff_q      <= '0;
            bout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            if (s1_to_s2) begin
                diff_q <= diff_d;
                bout_q <= bout_d;
                ovf_q  <= ovf_d;
                zero_q <= zero_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign bout      = bout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_csel_subtractor_pipe.sv
// Directed and scoreboarded bench for csel_subtractor_pipe at WIDTH=16, BLOCK=4.
module tb_csel_subtractor_pipe;

    localparam int W = 16;

    typedef struct packed {
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
        logic         zero;
    } res_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0] a, b, diff;
    logic         bin, bout, ovf, zero;

    int   vectors = 0;
    int   miscompares = 0;
    res_t sb[$];

    csel_subtractor_pipe #(.WIDTH(16), .BLOCK(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .bin      (bin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .diff     (diff),
        .bout     (bout),
        .ovf      (ovf),
        .zero     (zero)
    );

    always #5 clk = ~clk;

    // Arithmetic reference: 17-bit subtraction, top bit is the borrow.
    function automatic res_t model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi);
        logic [W:0] full;
        res_t r;
        full   = {1'b0, av} - {1'b0, bv} - {{W{1'b0}}, bi};
        r.diff = full[W-1:0];
        r.bout = full[W];
        r.ovf  = (av[W-1] != bv[W-1]) && (full[W-1] != av[W-1]);
        r.zero = (full[W-1:0] == '0);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi);
        in_valid = v;
        a        = av;
        b        = bv;
        bin      = bi;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic check_res(input string tag, input res_t expv);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_diff"},  32'(diff),      32'(expv.diff));
        check({tag, "_bout"},  32'(bout),      32'(expv.bout));
        check({tag, "_ovf"},   32'(ovf),       32'(expv.ovf));
        check({tag, "_zero"},  32'(zero),      32'(expv.zero));
    endtask

    // One isolated operation: result must appear two edges after presentation.
    task automatic directed(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                            input logic bi, input res_t expv);
        drive(1'b1, av, bv, bi);
        tick();
        drive(1'b0, '0, '0, 1'b0);
        check({tag, "_lat1"}, 32'(out_valid), 32'd0);
        tick();
        check_res(tag, expv);
        tick();
        check({tag, "_drain"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        res_t r0, r1, r2, r3, expv;
        int   ops_sent;

        rst_n     = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, '0, '0, 1'b0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_diff",      32'(diff),      32'd0);
        check("rst_flags",     32'({bout, ovf, zero}), 32'd0);

        // Hand-computed directed vectors: {diff, bout, ovf, zero}
        directed("basic",    16'h1234, 16'h0234, 1'b0, '{16'h1000, 1'b0, 1'b0, 1'b0});
        directed("wrap",     16'h0000, 16'h0001, 1'b0, '{16'hFFFF, 1'b1, 1'b0, 1'b0});
        directed("zero",     16'h0005, 16'h0004, 1'b1, '{16'h0000, 1'b0, 1'b0, 1'b1});
        directed("ovf_neg",  16'h8000, 16'h0001, 1'b0, '{16'h7FFF, 1'b0, 1'b1, 1'b0});
        directed("ovf_pos",  16'h7FFF, 16'hFFFF, 1'b0, '{16'h8000, 1'b1, 1'b1, 1'b0});
        directed("ripple",   16'h1000, 16'h0001, 1'b0, '{16'h0FFF, 1'b0, 1'b0, 1'b0});
        directed("bin_rip",  16'h0100, 16'h0000, 1'b1, '{16'h00FF, 1'b0, 1'b0, 1'b0});
        directed("full_wrap",16'h0000, 16'hFFFF, 1'b1, '{16'h0000, 1'b1, 1'b0, 1'b1});

        // Backpressure: four ops with the consumer stalled.
        r0 = model(16'h0010, 16'h0001, 1'b0);
        r1 = model(16'hABCD, 16'h1234, 1'b1);
        r2 = model(16'h0000, 16'h8000, 1'b0);
        r3 = model(16'hFFFF, 16'hFFFF, 1'b0);
        out_ready = 1'b0;
        drive(1'b1, 16'h0010, 16'h0001, 1'b0);
        #1 check("bp_rdy0", 32'(in_ready), 32'd1);
        tick();
        drive(1'b1, 16'hABCD, 16'h1234, 1'b1);
        #1 check("bp_rdy1", 32'(in_ready), 32'd1);
        tick();
        drive(1'b1, 16'h0000, 16'h8000, 1'b0);
        #1 check("bp_blocked", 32'(in_ready), 32'd0);
        check_res("bp_head", r0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_stall_rdy", 32'(in_ready), 32'd0);
            check_res("bp_stall", r0);
        end
        out_ready = 1'b1;
        #1 check("bp_release_rdy", 32'(in_ready), 32'd1);
        tick();
        check_res("bp_r1", r1);
        drive(1'b1, 16'hFFFF, 16'hFFFF, 1'b0);
        tick();
        check_res("bp_r2", r2);
        drive(1'b0, '0, '0, 1'b0);
        tick();
        check_res("bp_r3", r3);
        tick();
        check("bp_empty", 32'(out_valid), 32'd0);

        // Reset in the middle of traffic: both stages full, then discarded.
        out_ready = 1'b0;
        drive(1'b1, 16'h4444, 16'h1111, 1'b0);
        tick();
        drive(1'b1, 16'h5555, 16'h2222, 1'b0);
        tick();
        drive(1'b0, '0, '0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("mrst_out_valid", 32'(out_valid), 32'd0);
        check("mrst_in_ready",  32'(in_ready),  32'd1);
        check("mrst_diff",      32'(diff),      32'd0);
        check("mrst_flags",     32'({bout, ovf, zero}), 32'd0);
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mrst_no_output", 32'(out_valid), 32'd0);
        end

        // Random traffic with random backpressure, checked against the model in order.
        ops_sent = 0;
        for (int cyc = 0; cyc < 2000 && (ops_sent < 400 || sb.size() > 0); cyc++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (ops_sent < 400) begin
                drive(($urandom_range(0, 4) != 0), 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
            end else begin
                drive(1'b0, '0, '0, 1'b0);
            end
            #1;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("rnd_spurious", 32'(out_valid), 32'd0);
                end else begin
                    expv = sb.pop_front();
                    check_res("rnd", expv);
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back(model(a, b, bin));
                ops_sent++;
            end
            tick();
        end
        check("rnd_sent",    32'(ops_sent),  32'd400);
        check("rnd_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
